// File: rtl/hyperbus_burst_ctrl_if.sv
// Client command/data channel plus the request/response wires toward the HyperBus primary controller.
interface hyperbus_burst_ctrl_if #(
    parameter int WIDTH       = 8,
    parameter int ADDR_LENGTH = 32,
    parameter int DEPTH       = 16
);
    localparam int LEN_W = $clog2(DEPTH);

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_we;
    logic                   cmd_reg;
    logic [ADDR_LENGTH-1:0] cmd_adr;
    logic [LEN_W-1:0]       cmd_len;
    logic [2*WIDTH-1:0]     wdata;
    logic                   wvalid;
    logic                   wready;
    logic [2*WIDTH-1:0]     rdata;
    logic                   rvalid;
    logic                   done;
    logic                   err;
    logic [ADDR_LENGTH-1:0] hb_adr;
    logic [2*WIDTH-1:0]     hb_dat_o;
    logic                   hb_reg_space;
    logic                   hb_wrq;
    logic                   hb_rrq;
    logic                   hb_ready;
    logic                   hb_valid;
    logic [2*WIDTH-1:0]     hb_dat_i;
    logic                   hb_busy;
    logic                   hb_error;

    // slave is the sequencer; master is everything around it (client and controller)
    modport slave (
        input  cmd_valid, cmd_we, cmd_reg, cmd_adr, cmd_len, wdata, wvalid,
        input  hb_ready, hb_valid, hb_dat_i, hb_busy, hb_error,
        output cmd_ready, wready, rdata, rvalid, done, err,
        output hb_adr, hb_dat_o, hb_reg_space, hb_wrq, hb_rrq
    );

    modport master (
        output cmd_valid, cmd_we, cmd_reg, cmd_adr, cmd_len, wdata, wvalid,
        output hb_ready, hb_valid, hb_dat_i, hb_busy, hb_error,
        input  cmd_ready, wready, rdata, rvalid, done, err,
        input  hb_adr, hb_dat_o, hb_reg_space, hb_wrq, hb_rrq
    );
endinterface

// File: rtl/hyperbus_burst_ctrl.sv
// Burst request sequencer in front of the HyperBus primary controller: buffers a whole write
// burst before requesting, counts read strobes with an inactivity timeout, and reports done/err.
module hyperbus_burst_ctrl #(
    parameter int WIDTH       = 8,
    parameter int ADDR_LENGTH = 32,
    parameter int DEPTH       = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    hyperbus_burst_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W:0]   ONE       = (PTR_W + 1)'(1);

    typedef enum logic [2:0] {IDLE, WFILL, WBURST, RBURST, DRAIN} state_t;

    state_t                 state_reg;
    logic [2*WIDTH-1:0]     mem [DEPTH];
    logic [PTR_W:0]         wr_ptr_reg;
    logic [PTR_W:0]         rd_ptr_reg;
    logic [PTR_W:0]         remaining_reg;
    logic [PTR_W-1:0]       len_reg;
    logic [CNT_W-1:0]       idle_cnt_reg;
    logic                   abort_reg;
    logic [2*WIDTH-1:0]     rdata_reg;
    logic                   rvalid_reg;
    logic [ADDR_LENGTH-1:0] hb_adr_reg;
    logic                   hb_reg_space_reg;

    logic [PTR_W:0] fill_count;
    logic [PTR_W:0] fill_target;
    logic           cmd_ready_int;
    logic           wready_int;
    logic           push;
    logic           last_word;
    logic           done_int;

    // Pointers carry one extra bit so a buffer holding DEPTH words is not mistaken for empty.
    assign fill_count    = wr_ptr_reg - rd_ptr_reg;
    assign fill_target   = {1'b0, len_reg} + ONE;
    assign last_word     = (remaining_reg == ONE);
    assign cmd_ready_int = !rst && (state_reg == IDLE) && !bus.hb_busy;
    assign wready_int    = !rst && (state_reg == WFILL) && (fill_count != fill_target);
    assign push          = wready_int && bus.wvalid;
    assign done_int      = !rst && (state_reg == DRAIN) && (!bus.hb_busy || bus.hb_error);

    assign bus.cmd_ready    = cmd_ready_int;
    assign bus.wready       = wready_int;
    assign bus.rdata        = rdata_reg;
    assign bus.rvalid       = rvalid_reg;
    assign bus.done         = done_int;
    assign bus.err          = done_int && abort_reg;
    assign bus.hb_adr       = hb_adr_reg;
    assign bus.hb_reg_space = hb_reg_space_reg;
    assign bus.hb_dat_o     = mem[rd_ptr_reg[PTR_W-1:0]];
    // Requests fall in the very cycle the final beat is taken so the controller never starts another.
    assign bus.hb_wrq = !rst && (state_reg == WBURST) && !(last_word && bus.hb_ready);
    assign bus.hb_rrq = !rst && (state_reg == RBURST) && !(last_word && bus.hb_valid);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            remaining_reg    <= '0;
            len_reg          <= '0;
            idle_cnt_reg     <= '0;
            abort_reg        <= 1'b0;
            rdata_reg        <= '0;
            rvalid_reg       <= 1'b0;
            hb_adr_reg       <= '0;
            hb_reg_space_reg <= 1'b0;
        end else begin
            rvalid_reg <= 1'b0;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + ONE;
            end
            case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_int) begin
                        hb_adr_reg       <= bus.cmd_adr;
                        hb_reg_space_reg <= bus.cmd_reg;
                        len_reg          <= bus.cmd_len;
                        remaining_reg    <= {1'b0, bus.cmd_len} + ONE;
                        idle_cnt_reg     <= '0;
                        abort_reg        <= 1'b0;
                        state_reg        <= bus.cmd_we ? WFILL : RBURST;
                    end
                end
                WFILL: begin
                    if (bus.hb_error) begin
                        abort_reg <= 1'b1;
                        state_reg <= DRAIN;
                    end else if (push && ((fill_count + ONE) == fill_target)) begin
                        state_reg <= WBURST;
                    end
                end
                WBURST: begin
                    if (bus.hb_error) begin
                        abort_reg <= 1'b1;
                        state_reg <= DRAIN;
                    end else if (bus.hb_ready) begin
                        rd_ptr_reg    <= rd_ptr_reg + ONE;
                        remaining_reg <= remaining_reg - ONE;
                        if (last_word) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                RBURST: begin
                    if (bus.hb_error) begin
                        abort_reg <= 1'b1;
                        state_reg <= DRAIN;
                    end else if (bus.hb_valid) begin
                        rdata_reg     <= bus.hb_dat_i;
                        rvalid_reg    <= 1'b1;
                        remaining_reg <= remaining_reg - ONE;
                        idle_cnt_reg  <= '0;
                        if (last_word) begin
                            state_reg <= DRAIN;
                        end
                    end else if (idle_cnt_reg == IDLE_LAST) begin
                        abort_reg <= 1'b1;
                        state_reg <= DRAIN;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + 1'b1;
                    end
                end
                DRAIN: begin
                    // The controller's error state is sticky, so it is treated like busy falling.
                    if (!bus.hb_busy || bus.hb_error) begin
                        abort_reg  <= 1'b0;
                        wr_ptr_reg <= '0;
                        rd_ptr_reg <= '0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hyperbus_burst_ctrl.sv
// Bench for hyperbus_burst_ctrl: stimulus queues the expected beats, reads and completions;
// a negedge monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_hyperbus_burst_ctrl;
    localparam int WIDTH       = 8;
    localparam int ADDR_LENGTH = 32;
    localparam int DEPTH       = 16;
    localparam int TIMEOUT     = 16;
    localparam int DW          = 2 * WIDTH;
    localparam int LW          = $clog2(DEPTH);

    typedef struct packed {
        logic [DW-1:0] data;
        logic          wrq;
    } wbeat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hyperbus_burst_ctrl_if #(.WIDTH(WIDTH), .ADDR_LENGTH(ADDR_LENGTH), .DEPTH(DEPTH)) bus ();

    hyperbus_burst_ctrl #(
        .WIDTH(WIDTH), .ADDR_LENGTH(ADDR_LENGTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    wbeat_t        wq[$];
    logic [DW-1:0] rq[$];
    bit            dq[$];
    int            vectors     = 0;
    int            miscompares = 0;
    logic [DW-1:0] wbuf  [DEPTH];
    logic [DW-1:0] rbuf  [DEPTH];
    int            rgaps [DEPTH];
    wbeat_t        mon_w;
    logic [DW-1:0] mon_r;
    bit            mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input string why);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s at %0t", name, why, $time);
    endtask

    // Monitor: every controller beat, read word and completion must match the next queued entry.
    always @(negedge clk) begin
        if (bus.hb_ready) begin
            if (wq.size() == 0) flag("hb_beat", "beat taken with nothing expected");
            else begin
                mon_w = wq.pop_front();
                check("hb_dat_o", 64'(bus.hb_dat_o), 64'(mon_w.data));
                check("hb_wrq_beat", 64'(bus.hb_wrq), 64'(mon_w.wrq));
            end
        end
        if (bus.rvalid) begin
            if (rq.size() == 0) flag("rdata", "rvalid with nothing expected");
            else begin
                mon_r = rq.pop_front();
                check("rdata", 64'(bus.rdata), 64'(mon_r));
            end
        end
        if (bus.done) begin
            if (dq.size() == 0) flag("done", "done with nothing expected");
            else begin
                mon_e = dq.pop_front();
                check("err", 64'(bus.err), 64'(mon_e));
            end
        end
    end

    task automatic issue_cmd(input bit we, input logic [ADDR_LENGTH-1:0] adr, input int len);
        int t = 0;
        bit rg = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_reg   = rg;
        bus.cmd_adr   = adr;
        bus.cmd_len   = len[LW-1:0];
        @(negedge clk);
        while (!bus.cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.cmd_ready) flag("cmd_ready", "command never accepted");
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_adr   = ADDR_LENGTH'($urandom);
        check("hb_adr", 64'(bus.hb_adr), 64'(adr));
        check("hb_reg_space", 64'(bus.hb_reg_space), 64'(rg));
    endtask

    // err_after >= 0 raises hb_error after that many beats instead of finishing the burst.
    task automatic write_burst(input logic [ADDR_LENGTH-1:0] adr, input int len,
                               input bit wgap, input bit rgap, input int err_after);
        int nbeats = (err_after >= 0) ? err_after : len + 1;
        int i = 0;
        int k = 0;
        int tmo = 0;
        bit alt = 1'b1;
        wbeat_t e;
        for (int b = 0; b < nbeats; b++) begin
            e.data = wbuf[b];
            e.wrq  = (b != len);
            wq.push_back(e);
        end
        dq.push_back(err_after >= 0);
        $display("txn write adr=0x%0h len=%0d wgap=%0d rgap=%0d err_after=%0d", adr, len, wgap, rgap, err_after);
        issue_cmd(1'b1, adr, len);
        while (i <= len && tmo < 500) begin
            bus.wvalid = wgap ? alt : 1'b1;
            bus.wdata  = wbuf[i];
            alt = ~alt;
            @(negedge clk);
            if (bus.wvalid && bus.wready) i++;
            @(posedge clk); #1;
            tmo++;
        end
        bus.wvalid = 1'b0;
        if (i <= len) flag("wfill", "write buffer never filled");
        @(negedge clk);
        check("wready_full", 64'(bus.wready), 64'(0));
        check("hb_wrq_start", 64'(bus.hb_wrq), 64'(1));
        bus.hb_busy = 1'b1;
        tmo = 0;
        while (k < nbeats && tmo < 500) begin
            @(posedge clk); #1;
            bus.hb_ready = rgap ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (bus.hb_ready) k++;
            tmo++;
        end
        @(posedge clk); #1;
        bus.hb_ready = 1'b0;
        if (err_after >= 0) begin
            bus.hb_error = 1'b1;
            @(negedge clk);
            @(posedge clk); #1;
            @(negedge clk);
            check("hb_wrq_after_error", 64'(bus.hb_wrq), 64'(0));
            check("done_on_error", 64'(bus.done), 64'(1));
        end else begin
            repeat (2) @(posedge clk);
            #1;
            bus.hb_busy = 1'b0;
        end
    endtask

    // Strobe i arrives after rgaps[i] idle cycles; rvalid must follow every strobe by one cycle.
    task automatic read_burst(input logic [ADDR_LENGTH-1:0] adr, input int len);
        bit prev = 1'b0;
        for (int b = 0; b <= len; b++) rq.push_back(rbuf[b]);
        dq.push_back(1'b0);
        $display("txn read adr=0x%0h len=%0d", adr, len);
        issue_cmd(1'b0, adr, len);
        bus.hb_busy = 1'b1;
        @(negedge clk);
        check("hb_rrq_start", 64'(bus.hb_rrq), 64'(1));
        for (int i = 0; i <= len; i++) begin
            for (int g = 0; g < rgaps[i]; g++) begin
                @(posedge clk); #1;
                bus.hb_valid = 1'b0;
                @(negedge clk);
                check("rvalid_latency", 64'(bus.rvalid), 64'(prev));
                prev = 1'b0;
            end
            @(posedge clk); #1;
            bus.hb_valid = 1'b1;
            bus.hb_dat_i = rbuf[i];
            @(negedge clk);
            check("rvalid_latency", 64'(bus.rvalid), 64'(prev));
            check("hb_rrq_strobe", 64'(bus.hb_rrq), 64'(i != len));
            prev = 1'b1;
        end
        @(posedge clk); #1;
        bus.hb_valid = 1'b0;
        bus.hb_dat_i = DW'($urandom);
        @(negedge clk);
        check("rvalid_latency", 64'(bus.rvalid), 64'(prev));
        @(posedge clk); #1;
        bus.hb_busy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len;
        int t;
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_reg = 1'b0;
        bus.cmd_adr = '0; bus.cmd_len = '0; bus.wdata = '0; bus.wvalid = 1'b0;
        bus.hb_ready = 1'b0; bus.hb_valid = 1'b0; bus.hb_dat_i = '0;
        bus.hb_busy = 1'b0; bus.hb_error = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({bus.cmd_ready, bus.wready, bus.rvalid, bus.done,
                                    bus.err, bus.hb_wrq, bus.hb_rrq}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", 64'(bus.cmd_ready), 64'(1));

        // Four-word write, controller ready every cycle
        for (int b = 0; b < 4; b++) wbuf[b] = DW'(16'hA0A0 + 16'h0101 * b);
        write_burst(32'h100, 3, 1'b0, 1'b0, -1);

        // Two-word read, strobes three cycles apart
        rbuf[0] = 16'h1234; rbuf[1] = 16'h5678;
        rgaps[0] = 1; rgaps[1] = 2;
        read_burst(32'h200, 1);

        // Read that never receives a strobe
        $display("txn read timeout len=0");
        dq.push_back(1'b1);
        issue_cmd(1'b0, 32'h280, 0);
        bus.hb_busy = 1'b1;
        for (int c = 0; c < TIMEOUT; c++) begin
            @(negedge clk);
            if (c == TIMEOUT - 1) check("hb_rrq_before_timeout", 64'(bus.hb_rrq), 64'(1));
        end
        @(negedge clk);
        check("hb_rrq_timeout", 64'(bus.hb_rrq), 64'(0));
        check("no_done_while_busy", 64'(bus.done), 64'(0));
        @(posedge clk); #1;
        bus.hb_valid = 1'b1; bus.hb_dat_i = 16'hDEAD;
        @(posedge clk); #1;
        bus.hb_valid = 1'b0;
        @(negedge clk);
        check("late_strobe_rvalid", 64'(bus.rvalid), 64'(0));
        @(posedge clk); #1;
        bus.hb_busy = 1'b0;
        @(negedge clk);
        check("timeout_done", 64'(bus.done), 64'(1));

        // Full-depth write with wvalid on every other cycle
        for (int b = 0; b < DEPTH; b++) wbuf[b] = DW'($urandom);
        write_burst(32'h400, DEPTH - 1, 1'b1, 1'b0, -1);

        // Controller error after two beats; command must wait for busy to fall
        for (int b = 0; b < DEPTH; b++) wbuf[b] = DW'($urandom);
        write_burst(32'h500, 7, 1'b0, 1'b0, 2);
        @(posedge clk); #1;
        bus.hb_error = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_len = '0;
        repeat (3) begin
            @(negedge clk);
            check("cmd_ready_while_busy", 64'(bus.cmd_ready), 64'(0));
            check("hb_rrq_not_started", 64'(bus.hb_rrq), 64'(0));
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.hb_busy = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_error", 64'(bus.cmd_ready), 64'(1));

        // Reset in the middle of a read
        $display("txn read interrupted by rst");
        rq.push_back(16'hBEEF);
        issue_cmd(1'b0, 32'h300, 2);
        bus.hb_busy = 1'b1;
        @(posedge clk); #1;
        bus.hb_valid = 1'b1; bus.hb_dat_i = 16'hBEEF;
        @(posedge clk); #1;
        bus.hb_valid = 1'b0;
        @(negedge clk);
        check("rvalid_before_rst", 64'(bus.rvalid), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        bus.hb_busy = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("cmd_ready_in_rst", 64'(bus.cmd_ready), 64'(0));
        check("hb_rrq_after_rst", 64'(bus.hb_rrq), 64'(0));
        check("no_done_in_rst", 64'(bus.done), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_rst", 64'(bus.cmd_ready), 64'(1));
        rbuf[0] = 16'h0F0F; rbuf[1] = 16'hF0F0; rbuf[2] = 16'h5A5A;
        rgaps[0] = 0; rgaps[1] = 0; rgaps[2] = 3;
        read_burst(32'h304, 2);

        // Randomized mix of reads and writes
        for (int n = 0; n < 24; n++) begin
            len = $urandom_range(0, DEPTH - 1);
            for (int b = 0; b < DEPTH; b++) begin
                wbuf[b]  = DW'($urandom);
                rbuf[b]  = DW'($urandom);
                rgaps[b] = $urandom_range(0, 4);
            end
            if ($urandom_range(0, 1) == 1)
                write_burst(ADDR_LENGTH'($urandom), len, 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), -1);
            else
                read_burst(ADDR_LENGTH'($urandom), len);
        end

        t = 0;
        while ((wq.size() != 0 || rq.size() != 0 || dq.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("beats_outstanding", 64'(wq.size()), 64'(0));
        check("reads_outstanding", 64'(rq.size()), 64'(0));
        check("dones_outstanding", 64'(dq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
